alu2_issue_queue: RTL and testbench
===================================

Name: alu2_issue_queue

Overview:
In-order issue queue for the ALU2 execution port, placed directly upstream of the ALU2 execute stage. Accepts renamed ALU2 micro-ops from dispatch and holds each one until both source operands are valid. Source operands capture data from a result wakeup bus. Issues the head entry, with a registered output, onto the ALU2 execute input bus, honouring that stage's lock.

Parameters:
DEPTH, 4, number of queue entries; power of two, 2..8
PTR_W, 2, log2(DEPTH)

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous, active-low reset
iFREE_EX  in  1  pipeline flush; discards all entries and the output register
iDISP_VALID  in  1  dispatch offers a micro-op this cycle
iDISP_WRITEBACK  in  1  result is written to a register
iDISP_COMMIT_TAG  in  6  reorder tag
iDISP_CMD  in  5  ALU2 command code
iDISP_AFE  in  4  auxiliary function field
iDISP_SYS_REG / iDISP_LOGIC / iDISP_SHIFT  in  1 each  unit select; at most one is set; none set selects the adder
iDISP_SRC0_VALID / iDISP_SRC1_VALID  in  1 each  operand data is already present
iDISP_SRC0_TAG / iDISP_SRC1_TAG  in  6 each  producer commit tag when the operand is not valid
iDISP_SRC0 / iDISP_SRC1  in  32 each  operand data when valid
iDISP_DESTINATION_SYSREG  in  1  destination is a system register
iDISP_DESTINATION_REGNAME  in  6  destination register
iDISP_FLAGS_WRITEBACK  in  1  flags are written
iDISP_FLAGS_REGNAME  in  4  flags register
oDISP_LOCK  out  1  queue full; dispatch must hold
iWAKE_VALID  in  1  result broadcast
iWAKE_TAG  in  6  commit tag of the broadcast result
iWAKE_DATA  in  32  broadcast result data
iNEXT_LOCK  in  1  ALU2 execute stage cannot accept
oEX_VALID, oEX_WRITEBACK, oEX_COMMIT_TAG[6], oEX_CMD[5], oEX_AFE[4], oEX_SYS_REG, oEX_LOGIC, oEX_SHIFT, oEX_ADDER, oEX_SOURCE0[32], oEX_SOURCE1[32], oEX_DESTINATION_SYSREG, oEX_DESTINATION_REGNAME[6], oEX_FLAGS_WRITEBACK, oEX_FLAGS_REGNAME[4]  out  registered issue bus to ALU2 execute

Behaviour:
- Storage: circular buffer with write pointer, read pointer and a count of PTR_W+1 bits; pointers wrap modulo DEPTH.
- Reset: all entry valid bits 0, pointers 0, count 0; every oEX_* output 0; oDISP_LOCK 0.
- oDISP_LOCK = (count == DEPTH). This is combinational from registers only.
- Enqueue: on an edge where iDISP_VALID && !oDISP_LOCK, write the entry at the write pointer and increment it.
  - If a source is not valid and iWAKE_VALID && iWAKE_TAG equals that source's tag in the same cycle, store it already valid with iWAKE_DATA.
- Wakeup: every cycle, each stored entry whose source is waiting and whose tag equals iWAKE_TAG (with iWAKE_VALID) sets that source valid and latches iWAKE_DATA. This applies to both sources independently and to all entries in parallel.
- Ready: the head entry is ready when it exists and both sources are valid. There is no bypass: wakeup data becomes visible in an entry from the following cycle.
- Issue: when the head is ready and !iNEXT_LOCK, on the edge:
  - load the oEX_* register from the head, with oEX_VALID=1;
  - oEX_ADDER = !(SYS_REG | LOGIC | SHIFT);
  - pop the head.
- When nothing issues and !iNEXT_LOCK: oEX_VALID <= 0.
- When iNEXT_LOCK=1: the oEX_* register holds all of its values and nothing pops.
- Latency: a micro-op enqueued with both sources valid into an empty queue is presented on oEX_VALID 2 edges after the dispatch edge (enqueue edge, then issue edge).
- Order: issue is strictly in order. A non-ready head blocks younger entries.
- Simultaneous enqueue and pop: count is unchanged. This is legal when full, but oDISP_LOCK is still evaluated from the pre-edge count, so a full queue refuses dispatch in that cycle.
- iFREE_EX: has priority over enqueue, wakeup and issue. On that edge, pointers, count and valid bits clear and oEX_VALID <= 0. Other oEX fields are don't-care but are cleared to 0.
- Reset asserted mid-operation: everything clears asynchronously and the queue accepts dispatch from the first edge after release.

Decomposition:
- Shared package/header: ALU2 command codes (logic, shift and adder encodings), tag width 6, register name width 6, flags regname width 4.
- One natural sub-module, alu2_iq_entry, holds a single slot's operand-capture logic:
  - stores both operands with their valid bits and tags;
  - compares each waiting source tag against the wakeup bus;
  - merges the write port and the wakeup port.
  The queue instantiates DEPTH copies plus the pointer and count logic.

Test Plan:
- Ready op into an empty queue: dispatch tag 0x05, SRC0=0x10, SRC1=0x20, both valid, LOGIC=1 -> oEX_VALID=1 exactly 2 edges later with SOURCE0=0x10, SOURCE1=0x20, LOGIC=1, ADDER=0.
- Wakeup: dispatch with SRC1 waiting on tag 0x09, then iWAKE tag 0x09, data 0xDEADBEEF 3 cycles later -> issue occurs 2 edges after the wakeup edge with SOURCE1=0xDEADBEEF. A wakeup with tag 0x08 does not wake it.
- Same-cycle dispatch and wakeup match -> the entry is stored ready and issues on the next edge.
- Full queue: with iNEXT_LOCK=1, dispatch 4 ready ops -> oDISP_LOCK=1. A 5th offer is not accepted. Releasing the lock issues tags in dispatch order with no loss or duplication.
- Head blocking: head waiting, second entry ready -> nothing issues until the head wakes; then both issue in order on consecutive edges.
- iFREE_EX with 3 entries and oEX_VALID=1 -> next cycle oEX_VALID=0, oDISP_LOCK=0, and a new dispatch issues normally with pointers wrapping correctly.

Source files
------------

// File: rtl/alu2_iq_pkg.sv
// Shared widths, ALU2 command encodings and payload types for the ALU2 issue queue.
package alu2_iq_pkg;

  localparam int TAG_W   = 6;
  localparam int REG_W   = 6;
  localparam int FLAGS_W = 4;
  localparam int DATA_W  = 32;
  localparam int CMD_W   = 5;
  localparam int AFE_W   = 4;

  // ALU2 command codes, grouped by the unit that executes them.
  localparam logic [CMD_W-1:0] CMD_ADD   = 5'h00;
  localparam logic [CMD_W-1:0] CMD_SUB   = 5'h01;
  localparam logic [CMD_W-1:0] CMD_AND   = 5'h04;
  localparam logic [CMD_W-1:0] CMD_OR    = 5'h05;
  localparam logic [CMD_W-1:0] CMD_XOR   = 5'h06;
  localparam logic [CMD_W-1:0] CMD_SHL   = 5'h08;
  localparam logic [CMD_W-1:0] CMD_SHR   = 5'h09;
  localparam logic [CMD_W-1:0] CMD_SAR   = 5'h0A;
  localparam logic [CMD_W-1:0] CMD_SYSRD = 5'h10;

  // Non-operand part of a queued micro-op; travels unchanged to execute.
  typedef struct packed {
    logic               writeback;
    logic [TAG_W-1:0]   commit_tag;
    logic [CMD_W-1:0]   cmd;
    logic [AFE_W-1:0]   afe;
    logic               sys_reg;
    logic               logic_sel;
    logic               shift;
    logic               dest_sysreg;
    logic [REG_W-1:0]   dest_regname;
    logic               flags_writeback;
    logic [FLAGS_W-1:0] flags_regname;
  } alu2_uop_ctrl_t;

  // Registered issue bus towards ALU2 execute.
  typedef struct packed {
    logic                valid;
    alu2_uop_ctrl_t      ctrl;
    logic                adder;
    logic [DATA_W-1:0]   source0;
    logic [DATA_W-1:0]   source1;
  } alu2_ex_bus_t;

  // The adder is the default unit when no other unit is selected.
  function automatic logic sel_adder(input logic sys_reg, input logic logic_sel,
                                     input logic shift);
    return !(sys_reg | logic_sel | shift);
  endfunction

endpackage

// File: rtl/alu2_iq_entry.sv
// One issue-queue slot: entry valid bit plus two operands that capture
// their data either at dispatch or later from the result wakeup bus.
module alu2_iq_entry
  import alu2_iq_pkg::*;
(
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              clear_i,
  input  logic              write_i,
  input  logic              pop_i,
  input  logic              wr_src0_valid_i,
  input  logic [TAG_W-1:0]  wr_src0_tag_i,
  input  logic [DATA_W-1:0] wr_src0_data_i,
  input  logic              wr_src1_valid_i,
  input  logic [TAG_W-1:0]  wr_src1_tag_i,
  input  logic [DATA_W-1:0] wr_src1_data_i,
  input  logic              wake_valid_i,
  input  logic [TAG_W-1:0]  wake_tag_i,
  input  logic [DATA_W-1:0] wake_data_i,
  output logic              valid_o,
  output logic              src0_valid_o,
  output logic [DATA_W-1:0] src0_data_o,
  output logic              src1_valid_o,
  output logic [DATA_W-1:0] src1_data_o
);

  logic              valid_q, valid_d;
  logic [1:0]        src_valid_q, src_valid_d;
  logic [TAG_W-1:0]  src_tag_q  [2];
  logic [TAG_W-1:0]  src_tag_d  [2];
  logic [DATA_W-1:0] src_data_q [2];
  logic [DATA_W-1:0] src_data_d [2];

  logic              wr_valid [2];
  logic [TAG_W-1:0]  wr_tag   [2];
  logic [DATA_W-1:0] wr_data  [2];

  assign wr_valid[0] = wr_src0_valid_i;
  assign wr_valid[1] = wr_src1_valid_i;
  assign wr_tag[0]   = wr_src0_tag_i;
  assign wr_tag[1]   = wr_src1_tag_i;
  assign wr_data[0]  = wr_src0_data_i;
  assign wr_data[1]  = wr_src1_data_i;

  // Merge the dispatch write port with wakeup capture; clear wins over both.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_d     = valid_q;
    src_valid_d = src_valid_q;
    src_tag_d   = src_tag_q;
    src_data_d  = src_data_q;
    if (clear_i) begin
      valid_d     = 1'b0;
      src_valid_d = '0;
    end else if (write_i) begin
      valid_d = 1'b1;
      for (int s = 0; s < 2; s++) begin
        src_tag_d[s] = wr_tag[s];
        if (wr_valid[s]) begin
          src_valid_d[s] = 1'b1;
          src_data_d[s]  = wr_data[s];
        end else if (wake_valid_i && (wake_tag_i == wr_tag[s])) begin
          src_valid_d[s] = 1'b1;
          src_data_d[s]  = wake_data_i;
        end else begin
          src_valid_d[s] = 1'b0;
          src_data_d[s]  = wr_data[s];
        end
      end
    end else begin
      if (pop_i) valid_d = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (valid_q && !src_valid_q[s] && wake_valid_i && (wake_tag_i == src_tag_q[s])) begin
          src_valid_d[s] = 1'b1;
          src_data_d[s]  = wake_data_i;
        end
      end
    end
  end

  // Control state: valid bits are reset so a fresh queue holds nothing.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      // NOTE: sequential state uses non-blocking assignments only.
      valid_q     <= 1'b0;
      src_valid_q <= '0;
    end else begin
      valid_q     <= valid_d;
      src_valid_q <= src_valid_d;
    end
  end

  // Operand payload storage.
  always_ff @(posedge iCLOCK) begin
    // NOTE: tags and data are qualified by the valid bits, so they carry no reset.
    src_tag_q  <= src_tag_d;
    src_data_q <= src_data_d;
  end

  assign valid_o      = valid_q;
  assign src0_valid_o = src_valid_q[0];
  assign src0_data_o  = src_data_q[0];
  assign src1_valid_o = src_valid_q[1];
  assign src1_data_o  = src_data_q[1];

endmodule

// File: rtl/alu2_issue_queue.sv
// In-order ALU2 issue queue: circular buffer of operand-capturing slots,
// head issue onto a registered execute bus that respects the execute lock.
module alu2_issue_queue
  import alu2_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iFREE_EX,
  input  logic               iDISP_VALID,
  input  logic               iDISP_WRITEBACK,
  input  logic [TAG_W-1:0]   iDISP_COMMIT_TAG,
  input  logic [CMD_W-1:0]   iDISP_CMD,
  input  logic [AFE_W-1:0]   iDISP_AFE,
  input  logic               iDISP_SYS_REG,
  input  logic               iDISP_LOGIC,
  input  logic               iDISP_SHIFT,
  input  logic               iDISP_SRC0_VALID,
  input  logic               iDISP_SRC1_VALID,
  input  logic [TAG_W-1:0]   iDISP_SRC0_TAG,
  input  logic [TAG_W-1:0]   iDISP_SRC1_TAG,
  input  logic [DATA_W-1:0]  iDISP_SRC0,
  input  logic [DATA_W-1:0]  iDISP_SRC1,
  input  logic               iDISP_DESTINATION_SYSREG,
  input  logic [REG_W-1:0]   iDISP_DESTINATION_REGNAME,
  input  logic               iDISP_FLAGS_WRITEBACK,
  input  logic [FLAGS_W-1:0] iDISP_FLAGS_REGNAME,
  output logic               oDISP_LOCK,
  input  logic               iWAKE_VALID,
  input  logic [TAG_W-1:0]   iWAKE_TAG,
  input  logic [DATA_W-1:0]  iWAKE_DATA,
  input  logic               iNEXT_LOCK,
  output logic               oEX_VALID,
  output logic               oEX_WRITEBACK,
  output logic [TAG_W-1:0]   oEX_COMMIT_TAG,
  output logic [CMD_W-1:0]   oEX_CMD,
  output logic [AFE_W-1:0]   oEX_AFE,
  output logic               oEX_SYS_REG,
  output logic               oEX_LOGIC,
  output logic               oEX_SHIFT,
  output logic               oEX_ADDER,
  output logic [DATA_W-1:0]  oEX_SOURCE0,
  output logic [DATA_W-1:0]  oEX_SOURCE1,
  output logic               oEX_DESTINATION_SYSREG,
  output logic [REG_W-1:0]   oEX_DESTINATION_REGNAME,
  output logic               oEX_FLAGS_WRITEBACK,
  output logic [FLAGS_W-1:0] oEX_FLAGS_REGNAME
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             enq, issue, head_ready;

  logic              ent_valid      [DEPTH];
  logic              ent_src0_valid [DEPTH];
  logic              ent_src1_valid [DEPTH];
  logic [DATA_W-1:0] ent_src0_data  [DEPTH];
  logic [DATA_W-1:0] ent_src1_data  [DEPTH];
  alu2_uop_ctrl_t    ctrl_mem       [DEPTH];
  alu2_uop_ctrl_t    disp_ctrl;
  alu2_ex_bus_t      ex_q, ex_d;

  assign oDISP_LOCK = (count_q == (PTR_W+1)'(DEPTH));
  assign enq        = iDISP_VALID && !oDISP_LOCK;
  assign head_ready = ent_valid[rd_ptr_q] && ent_src0_valid[rd_ptr_q] && ent_src1_valid[rd_ptr_q];
  assign issue      = head_ready && !iNEXT_LOCK;

  assign disp_ctrl = '{writeback:       iDISP_WRITEBACK,
                       commit_tag:      iDISP_COMMIT_TAG,
                       cmd:             iDISP_CMD,
                       afe:             iDISP_AFE,
                       sys_reg:         iDISP_SYS_REG,
                       logic_sel:       iDISP_LOGIC,
                       shift:           iDISP_SHIFT,
                       dest_sysreg:     iDISP_DESTINATION_SYSREG,
                       dest_regname:    iDISP_DESTINATION_REGNAME,
                       flags_writeback: iDISP_FLAGS_WRITEBACK,
                       flags_regname:   iDISP_FLAGS_REGNAME};

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    alu2_iq_entry u_entry (
      .iCLOCK          (iCLOCK),
      .inRESET         (inRESET),
      .clear_i         (iFREE_EX),
      .write_i         (enq && (wr_ptr_q == PTR_W'(i))),
      .pop_i           (issue && (rd_ptr_q == PTR_W'(i))),
      .wr_src0_valid_i (iDISP_SRC0_VALID),
      .wr_src0_tag_i   (iDISP_SRC0_TAG),
      .wr_src0_data_i  (iDISP_SRC0),
      .wr_src1_valid_i (iDISP_SRC1_VALID),
      .wr_src1_tag_i   (iDISP_SRC1_TAG),
      .wr_src1_data_i  (iDISP_SRC1),
      .wake_valid_i    (iWAKE_VALID),
      .wake_tag_i      (iWAKE_TAG),
      .wake_data_i     (iWAKE_DATA),
      .valid_o         (ent_valid[i]),
      .src0_valid_o    (ent_src0_valid[i]),
      .src0_data_o     (ent_src0_data[i]),
      .src1_valid_o    (ent_src1_valid[i]),
      .src1_data_o     (ent_src1_data[i])
    );
  end

  // Control payload written at dispatch, read at the head.
  always_ff @(posedge iCLOCK) begin
    if (enq) ctrl_mem[wr_ptr_q] <= disp_ctrl;
  end

  // Next pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = enq   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (enq && !issue)      count_d = count_q + 1'b1;
    else if (!enq && issue) count_d = count_q - 1'b1;
  end

  // Pointer and count registers; flush empties the queue.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (iFREE_EX) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Issue bus contents for the next cycle: the head when it issues, else an empty bus.
  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid   = 1'b1;
      ex_d.ctrl    = ctrl_mem[rd_ptr_q];
      ex_d.adder   = sel_adder(ctrl_mem[rd_ptr_q].sys_reg, ctrl_mem[rd_ptr_q].logic_sel,
                               ctrl_mem[rd_ptr_q].shift);
      ex_d.source0 = ent_src0_data[rd_ptr_q];
      ex_d.source1 = ent_src1_data[rd_ptr_q];
    end
  end

  // Registered issue bus; holds while execute is locked, cleared by flush.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ex_q <= '0;
    end else if (iFREE_EX) begin
      ex_q <= '0;
    end else if (!iNEXT_LOCK) begin
      ex_q <= ex_d;
    end
  end

  assign oEX_VALID               = ex_q.valid;
  assign oEX_WRITEBACK           = ex_q.ctrl.writeback;
  assign oEX_COMMIT_TAG          = ex_q.ctrl.commit_tag;
  assign oEX_CMD                 = ex_q.ctrl.cmd;
  assign oEX_AFE                 = ex_q.ctrl.afe;
  assign oEX_SYS_REG             = ex_q.ctrl.sys_reg;
  assign oEX_LOGIC               = ex_q.ctrl.logic_sel;
  assign oEX_SHIFT               = ex_q.ctrl.shift;
  assign oEX_ADDER               = ex_q.adder;
  assign oEX_SOURCE0             = ex_q.source0;
  assign oEX_SOURCE1             = ex_q.source1;
  assign oEX_DESTINATION_SYSREG  = ex_q.ctrl.dest_sysreg;
  assign oEX_DESTINATION_REGNAME = ex_q.ctrl.dest_regname;
  assign oEX_FLAGS_WRITEBACK     = ex_q.ctrl.flags_writeback;
  assign oEX_FLAGS_REGNAME       = ex_q.ctrl.flags_regname;

endmodule

// File: tb/tb_alu2_issue_queue.sv
// Directed self-checking bench for the ALU2 issue queue.
module tb_alu2_issue_queue;
  import alu2_iq_pkg::*;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iFREE_EX;
  logic        iDISP_VALID, iDISP_WRITEBACK;
  logic [5:0]  iDISP_COMMIT_TAG;
  logic [4:0]  iDISP_CMD;
  logic [3:0]  iDISP_AFE;
  logic        iDISP_SYS_REG, iDISP_LOGIC, iDISP_SHIFT;
  logic        iDISP_SRC0_VALID, iDISP_SRC1_VALID;
  logic [5:0]  iDISP_SRC0_TAG, iDISP_SRC1_TAG;
  logic [31:0] iDISP_SRC0, iDISP_SRC1;
  logic        iDISP_DESTINATION_SYSREG;
  logic [5:0]  iDISP_DESTINATION_REGNAME;
  logic        iDISP_FLAGS_WRITEBACK;
  logic [3:0]  iDISP_FLAGS_REGNAME;
  logic        oDISP_LOCK;
  logic        iWAKE_VALID;
  logic [5:0]  iWAKE_TAG;
  logic [31:0] iWAKE_DATA;
  logic        iNEXT_LOCK;
  logic        oEX_VALID, oEX_WRITEBACK;
  logic [5:0]  oEX_COMMIT_TAG;
  logic [4:0]  oEX_CMD;
  logic [3:0]  oEX_AFE;
  logic        oEX_SYS_REG, oEX_LOGIC, oEX_SHIFT, oEX_ADDER;
  logic [31:0] oEX_SOURCE0, oEX_SOURCE1;
  logic        oEX_DESTINATION_SYSREG;
  logic [5:0]  oEX_DESTINATION_REGNAME;
  logic        oEX_FLAGS_WRITEBACK;
  logic [3:0]  oEX_FLAGS_REGNAME;

  int n_checks = 0;
  int n_fails  = 0;

  alu2_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFREE_EX(iFREE_EX),
    .iDISP_VALID(iDISP_VALID), .iDISP_WRITEBACK(iDISP_WRITEBACK),
    .iDISP_COMMIT_TAG(iDISP_COMMIT_TAG), .iDISP_CMD(iDISP_CMD), .iDISP_AFE(iDISP_AFE),
    .iDISP_SYS_REG(iDISP_SYS_REG), .iDISP_LOGIC(iDISP_LOGIC), .iDISP_SHIFT(iDISP_SHIFT),
    .iDISP_SRC0_VALID(iDISP_SRC0_VALID), .iDISP_SRC1_VALID(iDISP_SRC1_VALID),
    .iDISP_SRC0_TAG(iDISP_SRC0_TAG), .iDISP_SRC1_TAG(iDISP_SRC1_TAG),
    .iDISP_SRC0(iDISP_SRC0), .iDISP_SRC1(iDISP_SRC1),
    .iDISP_DESTINATION_SYSREG(iDISP_DESTINATION_SYSREG),
    .iDISP_DESTINATION_REGNAME(iDISP_DESTINATION_REGNAME),
    .iDISP_FLAGS_WRITEBACK(iDISP_FLAGS_WRITEBACK), .iDISP_FLAGS_REGNAME(iDISP_FLAGS_REGNAME),
    .oDISP_LOCK(oDISP_LOCK),
    .iWAKE_VALID(iWAKE_VALID), .iWAKE_TAG(iWAKE_TAG), .iWAKE_DATA(iWAKE_DATA),
    .iNEXT_LOCK(iNEXT_LOCK),
    .oEX_VALID(oEX_VALID), .oEX_WRITEBACK(oEX_WRITEBACK), .oEX_COMMIT_TAG(oEX_COMMIT_TAG),
    .oEX_CMD(oEX_CMD), .oEX_AFE(oEX_AFE), .oEX_SYS_REG(oEX_SYS_REG), .oEX_LOGIC(oEX_LOGIC),
    .oEX_SHIFT(oEX_SHIFT), .oEX_ADDER(oEX_ADDER),
    .oEX_SOURCE0(oEX_SOURCE0), .oEX_SOURCE1(oEX_SOURCE1),
    .oEX_DESTINATION_SYSREG(oEX_DESTINATION_SYSREG),
    .oEX_DESTINATION_REGNAME(oEX_DESTINATION_REGNAME),
    .oEX_FLAGS_WRITEBACK(oEX_FLAGS_WRITEBACK), .oEX_FLAGS_REGNAME(oEX_FLAGS_REGNAME)
  );

  always #5 iCLOCK = ~iCLOCK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic quiet();
    iDISP_VALID = 1'b0;
    iWAKE_VALID = 1'b0;
    iWAKE_TAG   = '0;
    iWAKE_DATA  = '0;
  endtask

  task automatic wake(input logic [5:0] t, input logic [31:0] d);
    iWAKE_VALID = 1'b1;
    iWAKE_TAG   = t;
    iWAKE_DATA  = d;
  endtask

  // unit = {sys_reg, logic, shift}; other fields are derived from the tag.
  task automatic offer(input logic [5:0] t, input logic [2:0] unit,
                       input logic s0v, input logic [5:0] s0t, input logic [31:0] s0,
                       input logic s1v, input logic [5:0] s1t, input logic [31:0] s1);
    iDISP_VALID               = 1'b1;
    iDISP_WRITEBACK           = 1'b1;
    iDISP_COMMIT_TAG          = t;
    iDISP_SYS_REG             = unit[2];
    iDISP_LOGIC               = unit[1];
    iDISP_SHIFT               = unit[0];
    iDISP_CMD                 = unit[2] ? CMD_SYSRD : unit[1] ? CMD_AND : unit[0] ? CMD_SHL : CMD_ADD;
    iDISP_AFE                 = t[3:0];
    iDISP_SRC0_VALID          = s0v;
    iDISP_SRC0_TAG            = s0t;
    iDISP_SRC0                = s0;
    iDISP_SRC1_VALID          = s1v;
    iDISP_SRC1_TAG            = s1t;
    iDISP_SRC1                = s1;
    iDISP_DESTINATION_SYSREG  = 1'b0;
    iDISP_DESTINATION_REGNAME = t ^ 6'h3F;
    iDISP_FLAGS_WRITEBACK     = t[0];
    iDISP_FLAGS_REGNAME       = t[3:0];
  endtask

  task automatic expect_issue(input string nm, input logic [5:0] t,
                              input logic [31:0] s0, input logic [31:0] s1);
    check({nm, " valid"}, 32'(oEX_VALID), 32'd1);
    check({nm, " tag"},   32'(oEX_COMMIT_TAG), 32'(t));
    check({nm, " src0"},  oEX_SOURCE0, s0);
    check({nm, " src1"},  oEX_SOURCE1, s1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    inRESET    = 1'b0;
    iFREE_EX   = 1'b0;
    iNEXT_LOCK = 1'b0;
    offer(6'h00, 3'b000, 1'b1, 6'h00, 32'h0, 1'b1, 6'h00, 32'h0);
    quiet();
    #12;
    check("reset ex_valid", 32'(oEX_VALID), 32'd0);
    check("reset lock",     32'(oDISP_LOCK), 32'd0);
    check("reset src0",     oEX_SOURCE0, 32'h0);
    check("reset tag",      32'(oEX_COMMIT_TAG), 32'h0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    tick();

    // Ready op into an empty queue: visible after the second edge.
    offer(6'h05, 3'b010, 1'b1, 6'h00, 32'h10, 1'b1, 6'h00, 32'h20);
    tick();
    quiet();
    check("lat enq edge valid", 32'(oEX_VALID), 32'd0);
    tick();
    expect_issue("lat", 6'h05, 32'h10, 32'h20);
    check("lat logic",   32'(oEX_LOGIC), 32'd1);
    check("lat adder",   32'(oEX_ADDER), 32'd0);
    check("lat cmd",     32'(oEX_CMD), 32'(CMD_AND));
    check("lat dest",    32'(oEX_DESTINATION_REGNAME), 32'h3A);
    check("lat flagsrn", 32'(oEX_FLAGS_REGNAME), 32'h5);
    tick();
    check("lat drain valid", 32'(oEX_VALID), 32'd0);

    // Wakeup: wrong tag is ignored, matching tag issues two edges later.
    offer(6'h0A, 3'b000, 1'b1, 6'h00, 32'h11, 1'b0, 6'h09, 32'h0);
    tick();
    quiet();
    wake(6'h08, 32'h12345678);
    tick();
    quiet();
    check("wake wrongtag valid", 32'(oEX_VALID), 32'd0);
    tick();
    check("wake wait valid", 32'(oEX_VALID), 32'd0);
    wake(6'h09, 32'hDEADBEEF);
    tick();
    quiet();
    check("wake edge valid", 32'(oEX_VALID), 32'd0);
    tick();
    expect_issue("wake", 6'h0A, 32'h11, 32'hDEADBEEF);
    check("wake adder", 32'(oEX_ADDER), 32'd1);
    tick();

    // Same-cycle dispatch and wakeup: stored ready.
    offer(6'h0C, 3'b001, 1'b0, 6'h0B, 32'h0, 1'b1, 6'h00, 32'h22);
    wake(6'h0B, 32'hCAFE0001);
    tick();
    quiet();
    tick();
    expect_issue("samecyc", 6'h0C, 32'hCAFE0001, 32'h22);
    check("samecyc shift", 32'(oEX_SHIFT), 32'd1);
    tick();

    // Full queue under execute lock; fifth offer refused; in-order drain.
    iNEXT_LOCK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(6'h20 + 6'(i), 3'b000, 1'b1, 6'h00, 32'h100 + 32'(i), 1'b1, 6'h00, 32'h200 + 32'(i));
      tick();
    end
    check("full lock", 32'(oDISP_LOCK), 32'd1);
    offer(6'h24, 3'b000, 1'b1, 6'h00, 32'h104, 1'b1, 6'h00, 32'h204);
    tick();
    quiet();
    check("full lock held", 32'(oDISP_LOCK), 32'd1);
    check("full ex idle", 32'(oEX_VALID), 32'd0);
    iNEXT_LOCK = 1'b0;
    tick();
    expect_issue("drain0", 6'h20, 32'h100, 32'h200);
    check("drain lock", 32'(oDISP_LOCK), 32'd0);
    tick();
    expect_issue("drain1", 6'h21, 32'h101, 32'h201);
    iNEXT_LOCK = 1'b1;
    tick();
    expect_issue("hold", 6'h21, 32'h101, 32'h201);
    iNEXT_LOCK = 1'b0;
    tick();
    expect_issue("drain2", 6'h22, 32'h102, 32'h202);
    tick();
    expect_issue("drain3", 6'h23, 32'h103, 32'h203);
    tick();
    check("drain empty", 32'(oEX_VALID), 32'd0);

    // Head blocking: a ready younger entry waits behind a waiting head.
    offer(6'h30, 3'b000, 1'b0, 6'h31, 32'h0, 1'b1, 6'h00, 32'h300);
    tick();
    offer(6'h32, 3'b000, 1'b1, 6'h00, 32'h320, 1'b1, 6'h00, 32'h321);
    tick();
    quiet();
    tick();
    check("block valid", 32'(oEX_VALID), 32'd0);
    wake(6'h31, 32'h55);
    tick();
    quiet();
    check("block wake edge", 32'(oEX_VALID), 32'd0);
    tick();
    expect_issue("block head", 6'h30, 32'h55, 32'h300);
    tick();
    expect_issue("block next", 6'h32, 32'h320, 32'h321);
    tick();
    check("block empty", 32'(oEX_VALID), 32'd0);

    // Flush with three queued entries and a held valid output.
    offer(6'h40, 3'b000, 1'b1, 6'h00, 32'h400, 1'b1, 6'h00, 32'h401);
    tick();
    quiet();
    tick();
    iNEXT_LOCK = 1'b1;
    for (int i = 1; i < 4; i++) begin
      offer(6'h40 + 6'(i), 3'b000, 1'b1, 6'h00, 32'h0, 1'b1, 6'h00, 32'h0);
      tick();
    end
    quiet();
    expect_issue("preflush", 6'h40, 32'h400, 32'h401);
    iFREE_EX = 1'b1;
    tick();
    iFREE_EX   = 1'b0;
    iNEXT_LOCK = 1'b0;
    check("flush valid", 32'(oEX_VALID), 32'd0);
    check("flush lock",  32'(oDISP_LOCK), 32'd0);
    check("flush tag",   32'(oEX_COMMIT_TAG), 32'd0);
    tick();
    check("flush empty", 32'(oEX_VALID), 32'd0);
    offer(6'h44, 3'b100, 1'b1, 6'h00, 32'h440, 1'b1, 6'h00, 32'h441);
    tick();
    quiet();
    tick();
    expect_issue("postflush", 6'h44, 32'h440, 32'h441);
    check("postflush sysreg", 32'(oEX_SYS_REG), 32'd1);
    tick();

    // Asynchronous reset mid-operation, then dispatch right after release.
    offer(6'h50, 3'b000, 1'b1, 6'h00, 32'h500, 1'b1, 6'h00, 32'h501);
    tick();
    quiet();
    tick();
    iNEXT_LOCK = 1'b1;
    offer(6'h52, 3'b000, 1'b1, 6'h00, 32'h520, 1'b1, 6'h00, 32'h521);
    tick();
    quiet();
    #2;
    inRESET = 1'b0;
    #1;
    check("async rst valid", 32'(oEX_VALID), 32'd0);
    check("async rst src0",  oEX_SOURCE0, 32'h0);
    #2;
    inRESET    = 1'b1;
    iNEXT_LOCK = 1'b0;
    offer(6'h51, 3'b000, 1'b1, 6'h00, 32'h510, 1'b1, 6'h00, 32'h511);
    tick();
    quiet();
    tick();
    expect_issue("post rst", 6'h51, 32'h510, 32'h511);
    tick();
    check("post rst empty", 32'(oEX_VALID), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
